// File: rtl/deserializer_core.sv
// Serial-to-parallel converter: collects WIDTH bits, one per clock edge,
// and publishes each completed word on data_out with a one-cycle out_valid.
//
// Ports:
//   clk       - single clock, all state updates on its rising edge
//   rst       - asynchronous active-low reset
//   data_in   - serial bit stream, one bit consumed per rising edge
//   data_out  - most recently completed parallel word (registered)
//   out_valid - one-cycle pulse when data_out is loaded with a new word
module deserializer_core #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;

    // Shift value including the bit sampled on this edge, so the final
    // bit of a word can go straight to data_out without an extra stage.
    always_comb begin
        sh_next = '0;
        if (MSB_FIRST) begin
            sh_next = (shreg << 1) | WIDTH'(data_in);
        end else begin
            sh_next = (shreg >> 1) | (WIDTH'(data_in) << (WIDTH - 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            cnt       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            shreg <= sh_next;
            if (cnt == LAST) begin
                data_out  <= sh_next;
                out_valid <= 1'b1;
                cnt       <= '0;
            end else begin
                out_valid <= 1'b0;
                cnt       <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_deserializer_core.sv
// Randomized self-checking bench for deserializer_core.
// Runs MSB-first and LSB-first instances on the same stream against a word model.
module tb_deserializer_core;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         data_in;
    logic [W-1:0] dout_m;
    logic [W-1:0] dout_l;
    logic         val_m;
    logic         val_l;

    int n_checks;
    int n_fail;

    // reference model: bits received since the last word/reset
    logic         q[$];
    logic [W-1:0] exp_m;
    logic [W-1:0] exp_l;
    logic         exp_v;

    deserializer_core #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_out  (dout_m),
        .out_valid (val_m)
    );

    deserializer_core #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_out  (dout_l),
        .out_valid (val_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dout_msb"}, 32'(dout_m), 32'(exp_m));
        check({tag, "_dout_lsb"}, 32'(dout_l), 32'(exp_l));
        check({tag, "_valid_msb"}, 32'(val_m), 32'(exp_v));
        check({tag, "_valid_lsb"}, 32'(val_l), 32'(exp_v));
    endtask

    task automatic model_reset();
        q.delete();
        exp_m = '0;
        exp_l = '0;
        exp_v = 1'b0;
    endtask

    // drive one bit, let one rising edge consume it, check at the negedge
    task automatic send(input logic b, input string tag);
        data_in = b;
        @(posedge clk);
        q.push_back(b);
        if (q.size() == W) begin
            for (int i = 0; i < W; i++) begin
                exp_m[W-1-i] = q[i];
                exp_l[i]     = q[i];
            end
            exp_v = 1'b1;
            q.delete();
        end else begin
            exp_v = 1'b0;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic send_word(input logic [W-1:0] w, input string tag);
        for (int i = W - 1; i >= 0; i--) send(w[i], tag);
    endtask

    // short reset pulse between edges; called at a negedge
    task automatic pulse_reset(input string tag);
        #2 rst = 1'b0;
        model_reset();
        #1 check_all({tag, "_async"});
        #1 rst = 1'b1;
    endtask

    initial begin
        logic [W-1:0] s6 [4];
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        data_in  = 1'b0;
        model_reset();
        s6[0] = 8'h00;
        s6[1] = 8'hFF;
        s6[2] = 8'hA5;
        s6[3] = 8'h3C;

        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // Scenario 1 (and LSB-first view of the same stream)
        send_word(8'hD5, "s1");
        check("s1_word", 32'(dout_m), 32'h0000_00D5);
        check("s4_word_lsb", 32'(dout_l), 32'h0000_00AB);
        check("s1_pulse", 32'(val_m), 32'h1);

        // Scenario 2: back-to-back second word
        send_word(8'hDE, "s2");
        check("s2_word", 32'(dout_m), 32'h0000_00DE);
        send(1'b0, "s2_after");
        check("s2_pulse_end", 32'(val_m), 32'h0);
        // re-align to word start
        pulse_reset("s2_realign");

        // Scenario 3: partial word discarded by a reset pulse
        send(1'b1, "s3_pre");
        send(1'b0, "s3_pre");
        send(1'b1, "s3_pre");
        send(1'b1, "s3_pre");
        pulse_reset("s3");
        check("s3_async_zero", 32'(dout_m), 32'h0);
        send_word(8'h0F, "s3");
        check("s3_word", 32'(dout_m), 32'h0000_000F);

        // Scenario 5: reset held while data_in toggles
        #2 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            data_in = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_all("s5_hold");
        end
        rst = 1'b1;

        // Scenario 6: four consecutive words
        for (int k = 0; k < 4; k++) begin
            send_word(s6[k], "s6");
            check("s6_word", 32'(dout_m), 32'(s6[k]));
        end

        // random stream with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom), "rnd");
            if ($urandom_range(0, 40) == 0) pulse_reset("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deserializer_core.md
DESERIALIZER_CORE -- requirements
Module: deserializer

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the parallel word width in bits.
REQ-002: Parameter MSB_FIRST, default 1, SHALL select bit order: 1 = first received bit lands in data_out[WIDTH-1]; 0 = first received bit lands in data_out[0].
REQ-003: Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004: Port rst, input, 1 bit, SHALL be the reset; asynchronous, active-low (rst=0 resets).
REQ-005: Port data_in, input, 1 bit, SHALL carry the serial bit stream, one bit sampled per rising clk edge.
REQ-006: Port data_out, output, WIDTH bits, SHALL present the most recently completed parallel word, registered.
REQ-007: Port out_valid, output, 1 bit, SHALL pulse high for exactly one clock cycle when data_out is loaded with a new word.

Function
REQ-008: The block SHALL hold an internal WIDTH-bit shift register and a bit counter of width ceil(log2(WIDTH)), counting 0..WIDTH-1.
REQ-009: Every rising clk edge with rst=1 SHALL sample data_in exactly once; there is no enable and no idle state: every edge consumes one bit.
REQ-010: With MSB_FIRST=1, each sampled bit SHALL shift into the LSB end, older bits moving toward the MSB; with MSB_FIRST=0, each bit SHALL shift into the MSB end, older bits moving toward the LSB.
REQ-011: On the edge sampling the WIDTH-th bit of a word (counter = WIDTH-1), data_out SHALL load the complete word including that bit, out_valid SHALL be 1 for the following cycle, and the counter SHALL wrap to 0.
REQ-012: On all other edges, data_out SHALL hold its value, out_valid SHALL be 0, and the counter SHALL increment by 1.
REQ-013: Latency: the word SHALL appear on data_out at the same rising edge that samples its last bit, with no extra pipeline stage.
REQ-014: Consecutive words SHALL be deserialized back-to-back with no gap cycles; bit 1 of word N+1 is the edge after bit WIDTH of word N.
REQ-015: A partial word SHALL never be driven on data_out.
REQ-016: data_in unknown (X) values SHALL propagate into the shift register without any special handling.

Reset
REQ-017: rst=0 SHALL immediately, independent of clk, force data_out=0, out_valid=0, the shift register to 0 and the counter to 0.
REQ-018: While rst=0, no bits SHALL be sampled, and data_out SHALL remain 0.
REQ-019: Reset asserted mid-word SHALL discard all partially received bits; after release, the first sampled bit SHALL be bit 1 of a new word.
REQ-020: The first rising clk edge with rst=1 after release SHALL sample bit 1.

Verification
REQ-021: Scenario 1 (WIDTH=8, MSB_FIRST=1): release reset, send 1,1,0,1,0,1,0,1 -> after the 8th edge, data_out=8'hD5 with a one-cycle out_valid pulse, and data_out=0 before that edge.
REQ-022: Scenario 2: immediately after Scenario 1, send 1,1,0,1,1,1,1,0 -> data_out=8'hDE on the 16th edge; out_valid is high only for the cycles after edges 8 and 16.
REQ-023: Scenario 3: send 4 bits 1,0,1,1, pulse rst=0 between clock edges, then send 0,0,0,0,1,1,1,1 -> data_out goes to 0 asynchronously, then becomes 8'h0F; no word containing the pre-reset bits appears.
REQ-024: Scenario 4 (MSB_FIRST=0): send 1,1,0,1,0,1,0,1 -> data_out=8'hAB.
REQ-025: Scenario 5: hold rst=0 for several cycles while toggling data_in -> data_out=0 and out_valid=0 throughout.
REQ-026: Scenario 6: stream 4 consecutive words 8'h00, 8'hFF, 8'hA5, 8'h3C -> each appears on data_out exactly 8 edges apart, each with one out_valid pulse.
